// File: rtl/mult_stage_pkg.sv
// Shared sizing and state types for the multiplier stage and its operand packer.
// Both Mult_Stage and mult_operand_packer take their lane count and widths from here.
package mult_stage_pkg;

    localparam int LANES  = 28;
    localparam int W_W    = 19;
    localparam int P_W    = 10;
    localparam int PROD_W = 26;
    localparam int CNT_W  = 5;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/mult_operand_packer.sv
// Packs one (weight, pixel) pair per cycle into LANES-wide vectors, double-buffered.
// Define PACKER_ZERO_PAD_EN to let in_last close a short, zero-padded vector.
module mult_operand_packer
    import mult_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 GlobalReset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_W-1:0]       in_weight,
    input  logic [P_W-1:0]       in_pixel,
    input  logic                 in_last,
    output logic [LANES*W_W-1:0] WeightX,
    output logic [LANES*P_W-1:0] PixelX,
    output logic                 vec_valid,
    input  logic                 vec_ready,
    output logic [CNT_W-1:0]     vec_lanes
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    pack_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [W_W-1:0]       fill_w_q [LANES];
    logic [P_W-1:0]       fill_p_q [LANES];
    logic [LANES*W_W-1:0] wx_q, wx_d;
    logic [LANES*P_W-1:0] px_q, px_d;
    logic                 vld_q, vld_d;
    logic [CNT_W-1:0]     lanes_q, lanes_d;
    logic                 acc, close, slot_free, load;

    assign in_ready  = (state_q == FILL) & GlobalReset;
    assign acc       = in_valid & in_ready;
    assign slot_free = ~vld_q | vec_ready;

`ifdef PACKER_ZERO_PAD_EN
    assign close = acc & ((cnt_q == LAST) | in_last);
`else
    logic unused_last;
    assign unused_last = in_last;
    assign close = acc & (cnt_q == LAST);
`endif

    // Lanes below cnt come from the fill buffer; lanes above it are padding.
    always_comb begin
        wx_d = '0;
        px_d = '0;
        for (int k = 0; k < LANES; k++) begin
            if (CNT_W'(k) < cnt_q) begin
                wx_d[W_W*k +: W_W] = fill_w_q[k];
                px_d[P_W*k +: P_W] = fill_p_q[k];
            end else if (CNT_W'(k) == cnt_q) begin
                wx_d[W_W*k +: W_W] = (state_q == FILL) ? in_weight : fill_w_q[k];
                px_d[P_W*k +: P_W] = (state_q == FILL) ? in_pixel  : fill_p_q[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        lanes_d = lanes_q;
        load    = 1'b0;
        if (vld_q & vec_ready) begin
            vld_d = 1'b0;
        end
        unique case (state_q)
            FILL: begin
                if (acc) begin
                    if (close) begin
                        if (slot_free) begin
                            load  = 1'b1;
                            cnt_d = '0;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (vec_ready) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            default: ;
        endcase
        if (load) begin
            vld_d   = 1'b1;
            lanes_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            lanes_q <= '0;
            wx_q    <= '0;
            px_q    <= '0;
            for (int k = 0; k < LANES; k++) begin
                fill_w_q[k] <= '0;
                fill_p_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            lanes_q <= lanes_d;
            if (load) begin
                wx_q <= wx_d;
                px_q <= px_d;
            end
            if (acc) begin
                fill_w_q[cnt_q] <= in_weight;
                fill_p_q[cnt_q] <= in_pixel;
            end
        end
    end

    assign WeightX   = wx_q;
    assign PixelX    = px_q;
    assign vec_valid = vld_q;
    assign vec_lanes = lanes_q;

endmodule

// File: tb/tb_mult_operand_packer.sv
// Directed, table-driven bench for mult_operand_packer.
// Covers reset, streaming, back-pressure/HOLD, extremes and in_last handling.
module tb_mult_operand_packer;
    import mult_stage_pkg::*;

    logic                 clk = 1'b0;
    logic                 GlobalReset;
    logic                 in_valid;
    logic                 in_ready;
    logic [W_W-1:0]       in_weight;
    logic [P_W-1:0]       in_pixel;
    logic                 in_last;
    logic [LANES*W_W-1:0] WeightX;
    logic [LANES*P_W-1:0] PixelX;
    logic                 vec_valid;
    logic                 vec_ready;
    logic [CNT_W-1:0]     vec_lanes;

    mult_operand_packer dut (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_weight  (in_weight),
        .in_pixel   (in_pixel),
        .in_last    (in_last),
        .WeightX    (WeightX),
        .PixelX     (PixelX),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_lanes  (vec_lanes)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W_W-1:0] lw(input int k);
        return WeightX[W_W*k +: W_W];
    endfunction

    function automatic logic [P_W-1:0] lp(input int k);
        return PixelX[P_W*k +: P_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W_W-1:0] wb, ws;
        logic [P_W-1:0] pb, ps;
        logic [W_W-1:0] ew0, ew13, ew27;
        logic [P_W-1:0] ep0, ep13, ep27;
    } rec_t;

    rec_t tbl [4];

    initial begin
        int     t_prev;
        int     t_now;
        logic   rdy_ok;

        tbl[0] = '{19'd1, 19'd1, 10'd0, 10'd2,
                   19'd1, 19'd14, 19'd28, 10'd0, 10'd26, 10'd54};
        tbl[1] = '{19'h7FFFF, 19'd0, 10'h3FF, 10'd0,
                   19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 10'h3FF, 10'h3FF, 10'h3FF};
        tbl[2] = '{19'h40000, 19'd1, 10'h3FF, 10'h3FF,
                   19'h40000, 19'h4000D, 19'h4001B, 10'h3FF, 10'h3F2, 10'h3E4};
        tbl[3] = '{19'h7FFF0, 19'd5, 10'h155, 10'd0,
                   19'h7FFF0, 19'h00031, 19'h00077, 10'h155, 10'h155, 10'h155};

        // ---- reset ----
        GlobalReset = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_weight   = '0;
        in_pixel    = '0;
        vec_ready   = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_vec_valid", 64'(vec_valid), 64'd0);
        chk("rst_vec_lanes", 64'(vec_lanes), 64'd0);
        GlobalReset = 1'b1;
        tick();
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // full vector held, then 10 pairs, then reset mid-fill
        for (int k = 0; k < 38; k++) begin
            in_valid  = 1'b1;
            in_weight = (k < 28) ? W_W'(k + 1) : W_W'(100 + k);
            in_pixel  = P_W'(k + 1);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(vec_valid), 64'd1);
        #2;
        GlobalReset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(vec_valid), 64'd0);
        chk("mid_rst_wx_zero", 64'(WeightX == '0), 64'd1);
        chk("mid_rst_px_zero", 64'(PixelX == '0), 64'd1);
        chk("mid_rst_lanes", 64'(vec_lanes), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        tick();
        GlobalReset = 1'b1;
        tick();

        // ---- table: back-to-back vectors with vec_ready held ----
        vec_ready = 1'b1;
        t_prev    = 0;
        for (int i = 0; i < 4; i++) begin
            rdy_ok = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                in_valid  = 1'b1;
                in_weight = tbl[i].wb + W_W'(k) * tbl[i].ws;
                in_pixel  = tbl[i].pb + P_W'(k) * tbl[i].ps;
                rdy_ok    = rdy_ok & in_ready;
                tick();
                if (k == LANES - 2) begin
                    chk($sformatf("t%0d_early_valid", i), 64'(vec_valid), 64'd0);
                end
            end
            t_now = cyc;
            chk($sformatf("t%0d_valid", i), 64'(vec_valid), 64'd1);
            chk($sformatf("t%0d_lanes", i), 64'(vec_lanes), 64'd28);
            chk($sformatf("t%0d_ready", i), 64'(rdy_ok), 64'd1);
            chk($sformatf("t%0d_w0", i), 64'(lw(0)), 64'(tbl[i].ew0));
            chk($sformatf("t%0d_w13", i), 64'(lw(13)), 64'(tbl[i].ew13));
            chk($sformatf("t%0d_w27", i), 64'(lw(27)), 64'(tbl[i].ew27));
            chk($sformatf("t%0d_p0", i), 64'(lp(0)), 64'(tbl[i].ep0));
            chk($sformatf("t%0d_p13", i), 64'(lp(13)), 64'(tbl[i].ep13));
            chk($sformatf("t%0d_p27", i), 64'(lp(27)), 64'(tbl[i].ep27));
            if (i > 0) begin
                chk($sformatf("t%0d_spacing", i), 64'(t_now - t_prev), 64'd28);
            end
            if (i == 1) begin
                chk("ext_wx_ones", 64'(WeightX == '1), 64'd1);
                chk("ext_px_ones", 64'(PixelX == '1), 64'd1);
            end
            t_prev = t_now;
        end

        // ---- back-pressure: 56 pairs with vec_ready low ----
        in_valid = 1'b0;
        tick();
        vec_ready = 1'b0;
        chk("bp_idle_drop", 64'(vec_valid), 64'd0);
        for (int k = 0; k < 56; k++) begin
            in_valid  = 1'b1;
            in_weight = W_W'(k + 1);
            in_pixel  = P_W'(k);
            tick();
        end
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(vec_valid), 64'd1);
        chk("bp_stable_w0", 64'(lw(0)), 64'd1);
        chk("bp_stable_w27", 64'(lw(27)), 64'd28);
        in_weight = W_W'(999);
        tick();
        chk("bp_hold_ready2", 64'(in_ready), 64'd0);
        chk("bp_stable_w0b", 64'(lw(0)), 64'd1);
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_v2_valid", 64'(vec_valid), 64'd1);
        chk("bp_v2_w0", 64'(lw(0)), 64'd29);
        chk("bp_v2_w27", 64'(lw(27)), 64'd56);
        chk("bp_v2_p0", 64'(lp(0)), 64'd28);
        chk("bp_v2_lanes", 64'(vec_lanes), 64'd28);
        chk("bp_v2_ready", 64'(in_ready), 64'd1);

        // ---- in_last handling ----
        vec_ready = 1'b1;
        tick();
        chk("last_idle", 64'(vec_valid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            in_valid  = 1'b1;
            in_weight = W_W'(k + 1);
            in_pixel  = P_W'(k + 1);
            in_last   = (k == 4);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
`ifdef PACKER_ZERO_PAD_EN
        chk("pad_valid", 64'(vec_valid), 64'd1);
        chk("pad_lanes", 64'(vec_lanes), 64'd5);
        chk("pad_w4", 64'(lw(4)), 64'd5);
        chk("pad_p4", 64'(lp(4)), 64'd5);
        chk("pad_w_hi_zero", 64'((WeightX >> (W_W*5)) == '0), 64'd1);
        chk("pad_p_hi_zero", 64'((PixelX >> (P_W*5)) == '0), 64'd1);
`else
        chk("nopad_no_valid", 64'(vec_valid), 64'd0);
        for (int k = 5; k < LANES; k++) begin
            in_valid  = 1'b1;
            in_weight = W_W'(k + 1);
            in_pixel  = P_W'(k + 1);
            tick();
            if (k == LANES - 2) begin
                chk("nopad_still_none", 64'(vec_valid), 64'd0);
            end
        end
        in_valid = 1'b0;
        chk("nopad_valid", 64'(vec_valid), 64'd1);
        chk("nopad_lanes", 64'(vec_lanes), 64'd28);
        chk("nopad_w4", 64'(lw(4)), 64'd5);
        chk("nopad_w27", 64'(lw(27)), 64'd28);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
